// File: rtl/strobe_compare_pkg.sv
// Shared definitions for the strobe comparator: FSM state encoding, strobe mode
// constants and default widths.
package strobe_compare_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;
  localparam int unsigned TICK_W        = 8;
  localparam int unsigned EDGE_W        = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_WINDOW = 1'b1;

endpackage

// File: rtl/strobe_compare_sync_2ff.sv
// Two-flop synchronizer for the asynchronous DUT response pin.
// Ports: CLK/RST (sync, active-high), d = async input, q = synchronized output.
module sync_2ff (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/strobe_compare.sv
// Tester-cycle strobe comparator: counts CLK ticks per tester cycle, compares the
// synchronized DUT pin against the latched expect value at an edge or over a
// window, and reports per-cycle pass/fail plus sticky/count/first-fail results.
// Ports: CLK, RST (sync, active-high), EN, CLEAR, HALT_ON_FAIL, MODE,
//   CYCLE_LENGTH, STROBE_EDGE, WINDOW_END, DUT_IN, EXPECT, MASK (inputs);
//   RESULT_VALID, RESULT_FAIL, FAIL_STICKY, FAIL_COUNT, FIRST_FAIL_IDX, HALTED.
module strobe_compare
  import strobe_compare_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              CLEAR,
  input  logic              HALT_ON_FAIL,
  input  logic              MODE,
  input  logic [TICK_W-1:0] CYCLE_LENGTH,
  input  logic [EDGE_W-1:0] STROBE_EDGE,
  input  logic [EDGE_W-1:0] WINDOW_END,
  input  logic              DUT_IN,
  input  logic              EXPECT,
  input  logic              MASK,
  output logic              RESULT_VALID,
  output logic              RESULT_FAIL,
  output logic              FAIL_STICKY,
  output logic [CNT_W-1:0]  FAIL_COUNT,
  output logic [CNT_W-1:0]  FIRST_FAIL_IDX,
  output logic              HALTED
);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [CNT_W-1:0]  cyc_idx_q, cyc_idx_d;
  logic              exp_q, exp_d;
  logic              mask_q, mask_d;
  logic              acc_q, acc_d;
  state_e            state_q, state_d;
  logic              res_valid_q, res_valid_d;
  logic              res_fail_q, res_fail_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0]  first_idx_q, first_idx_d;
  logic              halted_q, halted_d;

  logic              din_s;
  logic [TICK_W-1:0] se8, we8;
  logic              tick_one, tick_last;
  logic              exp_eff, mask_eff;
  logic              active, strobe_ok, in_win, miss, cyc_fail, fail_evt;

  sync_2ff u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (DUT_IN),
    .q   (din_s)
  );

  // Next-state, compare and result logic
  always_comb begin
    tick_d      = tick_q;
    cyc_idx_d   = cyc_idx_q;
    exp_d       = exp_q;
    mask_d      = mask_q;
    acc_d       = acc_q;
    state_d     = state_q;
    res_valid_d = 1'b0;
    res_fail_d  = 1'b0;
    sticky_d    = sticky_q;
    fail_cnt_d  = fail_cnt_q;
    first_idx_d = first_idx_q;

    se8       = {1'b0, STROBE_EDGE};
    we8       = {1'b0, WINDOW_END};
    tick_one  = (tick_q == TICK_W'(1));
    tick_last = (tick_q == CYCLE_LENGTH);

    // On the first tick the cycle's own EXPECT/MASK are on the pins, not yet latched
    exp_eff  = tick_one ? EXPECT : exp_q;
    mask_eff = tick_one ? MASK   : mask_q;

    active    = EN && (state_q != ST_HALT);
    strobe_ok = (se8 != '0) && (se8 <= CYCLE_LENGTH);
    if ((MODE == MODE_WINDOW) && (we8 >= se8)) begin
      in_win = (tick_q >= se8) && (tick_q <= we8);
    end else begin
      in_win = (tick_q == se8);
    end

    miss     = active && strobe_ok && in_win && !mask_eff && (din_s != exp_eff);
    cyc_fail = acc_q || miss;
    fail_evt = active && tick_last && cyc_fail && !CLEAR;

    // Timing state runs whenever enabled, including in HALT
    if (EN) begin
      if (tick_last) begin
        tick_d    = TICK_W'(1);
        cyc_idx_d = cyc_idx_q + CNT_W'(1);
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
      if (tick_one) begin
        exp_d  = EXPECT;
        mask_d = MASK;
      end
    end

    if (active) begin
      acc_d = tick_last ? 1'b0 : cyc_fail;
      if (tick_last) begin
        res_valid_d = 1'b1;
        res_fail_d  = cyc_fail && !CLEAR;
      end
    end

    if (fail_evt) begin
      if (fail_cnt_q != {CNT_W{1'b1}}) begin
        fail_cnt_d = fail_cnt_q + CNT_W'(1);
      end
      if (!sticky_q) begin
        first_idx_d = cyc_idx_q;
      end
      sticky_d = 1'b1;
    end

    if (CLEAR) begin
      fail_cnt_d  = '0;
      first_idx_d = '0;
      sticky_d    = 1'b0;
      acc_d       = 1'b0;
    end

    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        if (!EN) begin
          state_d = ST_IDLE;
        end else if (fail_evt && HALT_ON_FAIL) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (CLEAR) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    halted_d = (state_d == ST_HALT);
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      tick_q      <= TICK_W'(1);
      cyc_idx_q   <= '0;
      exp_q       <= 1'b0;
      mask_q      <= 1'b0;
      acc_q       <= 1'b0;
      state_q     <= ST_IDLE;
      res_valid_q <= 1'b0;
      res_fail_q  <= 1'b0;
      sticky_q    <= 1'b0;
      fail_cnt_q  <= '0;
      first_idx_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      cyc_idx_q   <= cyc_idx_d;
      exp_q       <= exp_d;
      mask_q      <= mask_d;
      acc_q       <= acc_d;
      state_q     <= state_d;
      res_valid_q <= res_valid_d;
      res_fail_q  <= res_fail_d;
      sticky_q    <= sticky_d;
      fail_cnt_q  <= fail_cnt_d;
      first_idx_q <= first_idx_d;
      halted_q    <= halted_d;
    end
  end

  assign RESULT_VALID   = res_valid_q;
  assign RESULT_FAIL    = res_fail_q;
  assign FAIL_STICKY    = sticky_q;
  assign FAIL_COUNT     = fail_cnt_q;
  assign FIRST_FAIL_IDX = first_idx_q;
  assign HALTED         = halted_q;

endmodule

// File: tb/tb_strobe_compare.sv
// Directed bench for strobe_compare (CNT_W=4). Expected per-cycle results go to a
// scoreboard queue when a tester cycle is driven and are popped by a monitor when
// RESULT_VALID appears; status outputs are checked against bench constants.
module tb_strobe_compare;
  import strobe_compare_pkg::*;

  localparam int unsigned CW = 4;

  logic          CLK = 1'b0;
  logic          RST, EN, CLEAR, HALT_ON_FAIL, MODE;
  logic [7:0]    CYCLE_LENGTH;
  logic [6:0]    STROBE_EDGE, WINDOW_END;
  logic          DUT_IN, EXPECT, MASK;
  logic          RESULT_VALID, RESULT_FAIL, FAIL_STICKY, HALTED;
  logic [CW-1:0] FAIL_COUNT, FIRST_FAIL_IDX;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cl       = 10;
  int   cyc      = 0;
  int   fi       = 0;
  logic sb[$];

  strobe_compare #(.CNT_W(CW)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .EN             (EN),
    .CLEAR          (CLEAR),
    .HALT_ON_FAIL   (HALT_ON_FAIL),
    .MODE           (MODE),
    .CYCLE_LENGTH   (CYCLE_LENGTH),
    .STROBE_EDGE    (STROBE_EDGE),
    .WINDOW_END     (WINDOW_END),
    .DUT_IN         (DUT_IN),
    .EXPECT         (EXPECT),
    .MASK           (MASK),
    .RESULT_VALID   (RESULT_VALID),
    .RESULT_FAIL    (RESULT_FAIL),
    .FAIL_STICKY    (FAIL_STICKY),
    .FAIL_COUNT     (FAIL_COUNT),
    .FIRST_FAIL_IDX (FIRST_FAIL_IDX),
    .HALTED         (HALTED)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every RESULT_VALID pulse must match a queued expectation
  always @(negedge CLK) begin
    if (RESULT_VALID === 1'b1) begin
      n_checks++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_result: observed RESULT_VALID=1 expected no pending result");
      end
      if (sb.size() != 0) begin
        logic e;
        e = sb.pop_front();
        n_checks++;
        assert (RESULT_FAIL === e) else begin
          n_fail++;
          $error("FAIL result_fail: observed %0b expected %0b", RESULT_FAIL, e);
        end
      end
    end
  end

  // One full tester cycle; g != 0 inverts DUT_IN for one CLK so the compare sees it at tick g
  task automatic tcycle(input logic exp, input logic msk, input logic din, input int g,
                        input logic ev, input logic ef);
    EN     = 1'b1;
    EXPECT = exp;
    MASK   = msk;
    DUT_IN = din;
    if (ev) sb.push_back(ef);
    for (int i = 1; i <= cl; i++) begin
      @(posedge CLK);
      #1;
      if (g != 0 && i == g - 3) DUT_IN = ~din;
      if (g != 0 && i == g - 2) DUT_IN = din;
      chk("valid_timing", 32'(RESULT_VALID), 32'((i == cl) && ev));
    end
    cyc++;
  endtask

  task automatic do_clear();
    EN    = 1'b0;
    CLEAR = 1'b1;
    @(posedge CLK);
    #1;
    CLEAR = 1'b0;
    chk("clear_count", 32'(FAIL_COUNT), 32'(0));
    chk("clear_first", 32'(FIRST_FAIL_IDX), 32'(0));
    chk("clear_sticky", 32'(FAIL_STICKY), 32'(0));
  endtask

  task automatic chk_status(input string tag, input int cnt, input int first, input logic st);
    chk({tag, "_count"}, 32'(FAIL_COUNT), 32'(cnt));
    chk({tag, "_first"}, 32'(FIRST_FAIL_IDX), 32'(first % 16));
    chk({tag, "_sticky"}, 32'(FAIL_STICKY), 32'(st));
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; CLEAR = 1'b0; HALT_ON_FAIL = 1'b0; MODE = MODE_EDGE;
    CYCLE_LENGTH = 8'd10; STROBE_EDGE = 7'd5; WINDOW_END = 7'd0;
    DUT_IN = 1'b0; EXPECT = 1'b0; MASK = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_valid", 32'(RESULT_VALID), 32'(0));
    chk("rst_halted", 32'(HALTED), 32'(0));
    chk_status("rst", 0, 0, 1'b0);
    RST = 1'b0;

    // Edge mode, matching data: a passing result every 10 CLKs
    repeat (3) tcycle(1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    chk_status("edge_pass", 0, 0, 1'b0);

    // Edge mode mismatch, then a glitch off the strobe tick is ignored
    fi = cyc;
    tcycle(1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1);
    chk_status("edge_fail", 1, fi, 1'b1);
    tcycle(1'b1, 1'b0, 1'b1, 4, 1'b1, 1'b0);
    chk_status("edge_offtick", 1, fi, 1'b1);

    // Masked mismatch passes; next unmasked mismatch counts
    do_clear();
    tcycle(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    chk_status("masked", 0, 0, 1'b0);
    fi = cyc;
    tcycle(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    chk_status("unmasked", 1, fi, 1'b1);

    // Window mode 3..6
    do_clear();
    MODE = MODE_WINDOW; STROBE_EDGE = 7'd3; WINDOW_END = 7'd6;
    tcycle(1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    fi = cyc;
    tcycle(1'b1, 1'b0, 1'b1, 4, 1'b1, 1'b1);
    chk_status("win_glitch", 1, fi, 1'b1);
    tcycle(1'b1, 1'b0, 1'b1, 8, 1'b1, 1'b0);
    chk_status("win_outside", 1, fi, 1'b1);
    // Inverted window collapses to the single tick STROBE_EDGE
    STROBE_EDGE = 7'd5; WINDOW_END = 7'd2;
    tcycle(1'b1, 1'b0, 1'b1, 4, 1'b1, 1'b0);
    tcycle(1'b1, 1'b0, 1'b1, 5, 1'b1, 1'b1);
    chk_status("win_inverted", 2, fi, 1'b1);

    // Strobe edge out of range -> no compare; edge at last tick still compares
    MODE = MODE_EDGE; STROBE_EDGE = 7'd0;
    tcycle(1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    STROBE_EDGE = 7'd12;
    tcycle(1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    STROBE_EDGE = 7'd10;
    tcycle(1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1);
    chk_status("edge_last", 3, fi, 1'b1);

    // Halt on fail in the third cycle, then CLEAR and resume
    do_clear();
    HALT_ON_FAIL = 1'b1; STROBE_EDGE = 7'd5;
    tcycle(1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    tcycle(1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    chk("pre_halt", 32'(HALTED), 32'(0));
    fi = cyc;
    tcycle(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    chk("halted", 32'(HALTED), 32'(1));
    repeat (2) tcycle(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("halt_hold", 32'(HALTED), 32'(1));
    chk_status("halt_hold", 1, fi, 1'b1);
    do_clear();
    chk("halt_clear", 32'(HALTED), 32'(0));
    HALT_ON_FAIL = 1'b0;
    tcycle(1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    chk("resume", 32'(HALTED), 32'(0));

    // Saturation over 20 consecutive fails with a short tester cycle
    do_clear();
    cl = 4; CYCLE_LENGTH = 8'd4; STROBE_EDGE = 7'd3;
    fi = cyc;
    for (int k = 1; k <= 20; k++) begin
      tcycle(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1);
      chk_status("sat", (k < 15) ? k : 15, fi, 1'b1);
    end

    // Reset in the middle of a failing cycle
    cl = 10; CYCLE_LENGTH = 8'd10; STROBE_EDGE = 7'd5;
    EN = 1'b1; EXPECT = 1'b1; MASK = 1'b0; DUT_IN = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge CLK);
      #1;
      chk("abort_valid", 32'(RESULT_VALID), 32'(0));
    end
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    cyc = 0;
    chk("abort_rst_valid", 32'(RESULT_VALID), 32'(0));
    chk("abort_rst_fail", 32'(RESULT_FAIL), 32'(0));
    chk("abort_rst_halted", 32'(HALTED), 32'(0));
    chk_status("abort_rst", 0, 0, 1'b0);
    tcycle(1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    fi = cyc;
    tcycle(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    chk_status("post_rst", 1, fi, 1'b1);

    @(negedge CLK);
    @(negedge CLK);
    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/strobe_compare.md
STROBE_COMPARE -- requirements
Module: strobe_compare

Interface
REQ-001 Parameter: CNT_W, 16, width of fail counter, cycle index and first-fail index.
REQ-002 CLK  input  1  clock; all state updates on posedge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 EN  input  1  run enable; low freezes all timing state.
REQ-005 CLEAR  input  1  synchronous clear of results; does not stop the run.
REQ-006 HALT_ON_FAIL  input  1  1 = stop comparing after the first failing tester cycle.
REQ-007 MODE  input  1  0 = edge strobe, 1 = window strobe.
REQ-008 CYCLE_LENGTH  input  8  CLK ticks per tester cycle (1..255).
REQ-009 STROBE_EDGE  input  7  tick at which the strobe opens.
REQ-010 WINDOW_END  input  7  last tick of the strobe window (MODE=1 only).
REQ-011 DUT_IN  input  1  asynchronous DUT response pin.
REQ-012 EXPECT  input  1  expected value for the current tester cycle.
REQ-013 MASK  input  1  1 = do not compare this tester cycle.
REQ-014 RESULT_VALID  output  1  one-CLK pulse per completed tester cycle.
REQ-015 RESULT_FAIL  output  1  fail flag for that cycle; qualified by RESULT_VALID.
REQ-016 FAIL_STICKY  output  1  set on any fail; cleared only by RST/CLEAR.
REQ-017 FAIL_COUNT  output  CNT_W  failing tester cycles, saturating.
REQ-018 FIRST_FAIL_IDX  output  CNT_W  cycle index of the first fail since RST/CLEAR.
REQ-019 HALTED  output  1  high in HALT state.

Function
REQ-020 Tick counter: 8 bits, range 1..CYCLE_LENGTH; increments when EN=1; wraps to 1 after reaching CYCLE_LENGTH; holds when EN=0.
REQ-021 Cycle index: CNT_W bits; increments on each wrap; wraps modulo 2^CNT_W.
REQ-022 DUT_IN passes through a two-flop synchronizer; compare logic sees DUT_IN delayed 2 CLKs.
REQ-023 EXPECT/MASK are latched when tick==1 and EN=1; they hold for the whole tester cycle.
REQ-024 Edge mode: the synced DUT_IN is compared once, at tick==STROBE_EDGE.
REQ-025 Window mode: the synced DUT_IN is compared on every tick from STROBE_EDGE to WINDOW_END inclusive; any mismatch fails the cycle.
REQ-026 If WINDOW_END < STROBE_EDGE, the window is the single tick STROBE_EDGE.
REQ-027 If STROBE_EDGE==0 or STROBE_EDGE > CYCLE_LENGTH, no compare occurs and the cycle passes.
REQ-028 If the latched MASK=1, the cycle passes regardless of data.
REQ-029 At tick==CYCLE_LENGTH with EN=1, RESULT_VALID/RESULT_FAIL are registered and asserted the following CLK (latency 1); the per-cycle mismatch accumulator is then cleared.
REQ-030 FSM states:
- IDLE: entered at reset; goes to RUN when EN=1.
- RUN: goes to IDLE when EN=0, with tick and accumulators held; goes to HALT on a failing result when HALT_ON_FAIL=1.
- HALT: no compares and no RESULT_VALID; counters keep running; exits to IDLE only on CLEAR or RST.
REQ-031 On each failing result:
- FAIL_COUNT increments, saturating at all-ones.
- FIRST_FAIL_IDX loads the cycle index, only while FAIL_STICKY is 0.
- FAIL_STICKY sets.
REQ-032 CLEAR zeroes FAIL_COUNT, FIRST_FAIL_IDX, FAIL_STICKY and the accumulator. CLEAR wins over a simultaneous failing result, which is discarded. Tick counter and cycle index are unaffected.
REQ-033 Changing CYCLE_LENGTH to a value below the current tick makes the counter run on to 255, wrap to 0, then match; the programmer avoids this by changing it only with EN=0.

Reset
REQ-034 RST sets tick=1 and all other state to zero: cycle index, synchronizer, latched EXPECT/MASK, accumulator, every output, FSM=IDLE.
REQ-035 RST asserted mid-cycle aborts the cycle and produces no RESULT_VALID; RST has priority over CLEAR and EN.

Structure
REQ-036 Shared package holds the FSM state encoding (IDLE/RUN/HALT), the MODE constants (EDGE=0, WINDOW=1) and the CNT_W default.
REQ-037 The two-flop synchronizer is a separate sub-module named sync_2ff; everything else is in strobe_compare.

Verification
REQ-038 CYCLE_LENGTH=10, STROBE_EDGE=5, MODE=0, EXPECT=1, DUT_IN=1 -> RESULT_VALID once every 10 CLKs, RESULT_FAIL=0, FAIL_COUNT=0.
REQ-039 MODE=1, window 3..6, DUT_IN glitches low for 1 CLK landing at synced tick 4, EXPECT=1 -> RESULT_FAIL=1, FAIL_COUNT=1, FIRST_FAIL_IDX = that cycle index.
REQ-040 MASK=1 on a cycle with DUT_IN != EXPECT -> RESULT_FAIL=0; the next unmasked mismatch -> FAIL_COUNT=1.
REQ-041 HALT_ON_FAIL=1, fail in cycle 3 -> HALTED=1, no further RESULT_VALID; CLEAR -> HALTED=0, FAIL_COUNT=0; EN=1 resumes RUN.
REQ-042 CNT_W=4, 20 consecutive failing cycles -> FAIL_COUNT saturates at 15 and FIRST_FAIL_IDX is unchanged after the first fail.
REQ-043 RST pulsed at tick 7 of a failing cycle -> no RESULT_VALID, all outputs 0, tick restarts at 1.
